// File: rtl/quantser_pkg.sv
// Shared definitions for the quantizing serializer.
// Holds the default data widths and the controller state encoding used by
// quantser and its bus interface.
package quantser_pkg;

    localparam int BDIN_DEF     = 32;
    localparam int BDOUTMAX_DEF = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage : quantser_pkg

// File: rtl/quantser_if.sv
// Bus bundle for quantser: load strobe, data word, bit-window controls and serial output.
// Ports: start/din/msbidx/bdout flow from master to slave; dout returns from slave.
// No handshake: start is a strobe and dout is a free-running registered bit.
interface quantser_if
    import quantser_pkg::*;
#(
    parameter int BDIN     = BDIN_DEF,
    parameter int BDOUTMAX = BDOUTMAX_DEF
) ();

    localparam int MAXBDIP = $clog2(BDIN);
    localparam int MAXBDOP = $clog2(BDOUTMAX);

    logic               start;
    logic [BDIN-1:0]    din;
    logic [MAXBDIP-1:0] msbidx;
    logic [MAXBDOP-1:0] bdout;
    logic               dout;

    modport master (
        output start, din, msbidx, bdout,
        input  dout
    );

    modport slave (
        input  start, din, msbidx, bdout,
        output dout
    );

endinterface : quantser_if

// File: rtl/quantser.sv
// Quantizing serializer: emits din[msbidx] down to din[msbidx-bdout] MSB-first on dout.
// Latency: bit k is on dout in cycle k+1 after the start edge; dout is 0 once idle.
// No backpressure: a start always wins over a running sequence; clr wins over start.
// Ports: clk (rising-edge clock), clr (sync active-high reset), bus (quantser_if.slave).
module quantser
    import quantser_pkg::*;
#(
    parameter int BDIN     = BDIN_DEF,
    parameter int BDOUTMAX = BDOUTMAX_DEF
) (
    input  logic       clk,
    input  logic       clr,
    quantser_if.slave  bus
);

    localparam int MAXBDIP = $clog2(BDIN);
    localparam int MAXBDOP = $clog2(BDOUTMAX);

    localparam logic [MAXBDIP-1:0] TOP_IDX = MAXBDIP'(BDIN - 1);
    localparam logic [MAXBDOP:0]   CNT_ONE = {{MAXBDOP{1'b0}}, 1'b1};

    state_t           r_state;
    logic [BDIN-1:0]  r_shift;   // remaining bits, next one to emit at the MSB
    logic [MAXBDOP:0] r_cnt;     // bits still to emit after the one on dout
    logic             r_dout;

    logic [MAXBDIP-1:0] w_shamt;
    logic [BDIN-1:0]    w_aligned;

    // Left-align the captured word so din[msbidx] sits at the MSB. Bits below
    // index 0 are filled by the zeros shifted in, which gives the zero padding
    // when msbidx < bdout for free.
    assign w_shamt   = TOP_IDX - bus.msbidx;
    assign w_aligned = bus.din << w_shamt;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_dout  <= 1'b0;
        end else if (bus.start) begin
            // The first bit goes out on the start edge itself; the shift
            // register keeps only what comes after it.
            r_dout  <= bus.din[bus.msbidx];
            r_shift <= w_aligned << 1;
            r_cnt   <= {1'b0, bus.bdout};
            r_state <= (bus.bdout != '0) ? ST_SHIFT : ST_IDLE;
        end else begin
            case (r_state)
                ST_SHIFT: begin
                    r_dout  <= r_shift[BDIN-1];
                    r_shift <= r_shift << 1;
                    r_cnt   <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_dout <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dout = r_dout;

endmodule : quantser

// File: tb/tb_quantser.sv
module tb_quantser;

    logic clk;
    logic clr;

    int n_tests;
    int n_fail;

    quantser_if #(.BDIN(32), .BDOUTMAX(32)) bus ();

    quantser #(.BDIN(32), .BDOUTMAX(32)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply a start strobe for exactly one edge, then scramble the bus inputs
    // so any dependence on live inputs during serialization shows up.
    task automatic start_seq(input logic [31:0] d, input logic [4:0] msb, input logic [4:0] bd);
        @(negedge clk);
        bus.din    = d;
        bus.msbidx = msb;
        bus.bdout  = bd;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.din    = ~d;
        bus.msbidx = ~msb;
        bus.bdout  = ~bd;
    endtask

    // Collect nbits bits MSB-first, starting from the bit currently on dout.
    task automatic collect(input int nbits, output logic [31:0] v);
        v = '0;
        for (int k = 0; k < nbits; k++) begin
            v = {v[30:0], bus.dout};
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic check_idle(input string name);
        n_tests++;
        if (bus.dout !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: dout got %b expected 0", name, bus.dout);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        clr        = 1'b1;
        bus.start  = 1'b1;
        bus.din    = 32'hFFFF_FFFF;
        bus.msbidx = 5'd31;
        bus.bdout  = 5'd31;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset_dout_clr_over_start");
        bus.start = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk);
        #1;
        check_idle("reset_dout_after_release");
    endtask

    task automatic test_single_bit();
        logic [31:0] v;
        start_seq(32'h1, 5'd0, 5'd0);
        collect(1, v);
        check_val("bd0_msb0_din1", v, 32'h1);
        check_idle("bd0_msb0_tail");
        start_seq(32'h8, 5'd3, 5'd0);
        collect(1, v);
        check_val("bd0_msb3_din8", v, 32'h1);
        start_seq(32'h8000_0000, 5'd31, 5'd0);
        collect(1, v);
        check_val("bd0_msb31_top", v, 32'h1);
        check_idle("bd0_msb31_tail");
    endtask

    task automatic test_two_bit();
        logic [31:0] v;
        start_seq(32'h2, 5'd1, 5'd1);
        collect(2, v);
        check_val("bd1_msb1_din2", v, 32'h2);
        check_idle("bd1_msb1_tail");
        start_seq(32'h8, 5'd3, 5'd1);
        collect(2, v);
        check_val("bd1_msb3_din8", v, 32'h2);
        start_seq(32'h8000_0000, 5'd31, 5'd1);
        collect(2, v);
        check_val("bd1_msb31_top", v, 32'h2);
        check_idle("bd1_msb31_tail");
    endtask

    task automatic test_full_width();
        logic [31:0] v;
        start_seq(32'h5, 5'd31, 5'd31);
        collect(32, v);
        check_val("bd31_msb31_din5", v, 32'h5);
        check_idle("bd31_33rd_cycle");
        start_seq(32'hA5C3_0F96, 5'd31, 5'd31);
        collect(32, v);
        check_val("bd31_pattern", v, 32'hA5C3_0F96);
    endtask

    task automatic test_padding();
        logic [31:0] v;
        start_seq(32'h3, 5'd1, 5'd3);
        collect(4, v);
        check_val("bd3_msb1_pad", v, 32'd12);
        check_idle("bd3_msb1_tail");
        // Truncation: window bits 6..3 of 0xB7 (1011_0111) -> 0110
        start_seq(32'hB7, 5'd6, 5'd3);
        collect(4, v);
        check_val("bd3_msb6_trunc", v, 32'h6);
    endtask

    task automatic test_clr_abort();
        logic [31:0] v;
        int stray;
        start_seq(32'hFFFF_FFFF, 5'd31, 5'd31);
        collect(10, v);
        check_val("clr_prefix_bits", v, 32'h3FF);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        stray = 0;
        for (int k = 0; k < 25; k++) begin
            if (bus.dout !== 1'b0) stray++;
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL clr_abort_quiet: %0d nonzero cycles, expected 0", stray);
        end
        start_seq(32'h3, 5'd1, 5'd1);
        collect(2, v);
        check_val("clr_restart", v, 32'h3);
        check_idle("clr_restart_tail");
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        // Restart in the middle of a long sequence
        start_seq(32'hFFFF_FFFF, 5'd31, 5'd31);
        collect(3, v);
        start_seq(32'hA, 5'd3, 5'd3);
        collect(4, v);
        check_val("abort_restart", v, 32'hA);
        check_idle("abort_restart_tail");
        // Held start restarts every edge; only the last load runs to completion
        @(negedge clk);
        bus.din    = 32'hFFFF_FFFF;
        bus.msbidx = 5'd31;
        bus.bdout  = 5'd31;
        bus.start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.din    = 32'h4;
        bus.msbidx = 5'd3;
        bus.bdout  = 5'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.din   = 32'hFFFF_FFFF;
        collect(4, v);
        check_val("held_start_last", v, 32'h4);
        check_idle("held_start_tail");
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        clr        = 1'b0;
        bus.start  = 1'b0;
        bus.din    = '0;
        bus.msbidx = '0;
        bus.bdout  = '0;
        test_reset();
        test_single_bit();
        test_two_bit();
        test_full_width();
        test_padding();
        test_clr_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_quantser

// File: doc/quantser.md
QUANTSER -- requirements
Module: quantser

Interface
REQ-001 Parameter BDIN, default 32, input data bit depth.
REQ-002 Parameter BDOUTMAX, default 32, maximum output precision in bits (BDOUTMAX <= BDIN).
REQ-003 Derived localparams: MAXBDIP = $clog2(BDIN) and MAXBDOP = $clog2(BDOUTMAX).
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock; all state changes on its rising edge.
REQ-006 clr  input  1  synchronous active-high reset; clears state and output register.
REQ-007 msbidx  input  MAXBDIP  bit position in din of the first (most significant) bit to emit.
REQ-008 bdout  input  MAXBDOP  output bit depth minus one (0 means 1 bit; 31 means 32 bits).
REQ-009 start  input  1  load-and-start strobe, sampled on the rising edge of clk.
REQ-010 din  input  BDIN  unsigned input word.
REQ-011 dout  output  1  serialized quantized output, driven from a register.

Function
REQ-012 On a rising edge with start=1 and clr=0, the block SHALL capture din, msbidx and bdout into internal registers.
REQ-013 On that same edge, dout SHALL be loaded with din[msbidx].
REQ-014 On each following edge, dout SHALL take the next lower bit of the captured word: din[msbidx-1], din[msbidx-2], and so on.
REQ-015 Serialization SHALL be MSB-first; exactly bdout+1 bits SHALL be emitted, each held for one cycle.
REQ-016 Emitted bits SHALL be din[msbidx] down to din[msbidx-bdout].
REQ-017 Latency: bit k (k=0..bdout) SHALL be valid on dout during cycle k+1 after the start edge.
REQ-018 Quantization SHALL be truncation: bits below msbidx-bdout are discarded, with no rounding and no saturation.
REQ-019 Any emitted bit position below index 0 (msbidx < bdout) SHALL be emitted as 0.
REQ-020 After the last bit has been emitted, the block SHALL return to idle and dout SHALL be 0 until the next start.
REQ-021 Changes to din, msbidx and bdout after the start edge SHALL NOT affect the sequence in progress.
REQ-022 A start asserted while a sequence is in progress SHALL abort it and restart with the newly captured values on that edge.
REQ-023 start held high for several cycles SHALL restart on every edge.
REQ-024 States: IDLE and SHIFT.
- IDLE -> SHIFT on start when bdout > 0.
- SHIFT -> IDLE after the final bit is loaded.
- For bdout = 0, the single bit is loaded and the block stays or returns to IDLE, holding that bit one cycle and then outputting 0.
REQ-025 Remaining-bit count SHALL use MAXBDOP+1 bits so that 32-bit depth does not wrap.

Reset
REQ-026 With clr=1 at a rising edge, dout SHALL be 0, the state SHALL be IDLE and the count and captured registers SHALL be 0.
REQ-027 clr SHALL take priority over start.
REQ-028 clr asserted mid-serialization SHALL abort the sequence; no further bits are emitted until a new start.
REQ-029 No asynchronous reset path SHALL exist.

Structure
REQ-030 The default values of BDIN and BDOUTMAX and the state enum typedef SHALL reside in a shared package; the module parameters default from it.
REQ-031 The design SHALL be a single module; an optional down-counter submodule quantser_ctr is permitted, but no other submodules.
REQ-032 Implementation SHALL use a shift register of captured din aligned by msbidx, or a bit-index pointer; both are acceptable.

Verification
REQ-033 bdout=0, msbidx=0, din=1, start one cycle -> dout=1 on the next cycle, then 0.
REQ-034 bdout=0, msbidx=3, din=0x8 -> 1-bit result 1; with msbidx=31 and din=0x80000000 -> 1.
REQ-035 bdout=1, msbidx=1, din=0x2 -> bits 1,0 (value 2); with msbidx=3 and din=0x8 -> 2; with msbidx=31 and din=0x80000000 -> 2.
REQ-036 bdout=31, msbidx=31, din=5 -> 32 bits deserialized MSB-first equal 5; dout=0 on the 33rd cycle.
REQ-037 bdout=3, msbidx=1, din=0x3 -> bits 1,1,0,0 (value 12), covering the below-zero padding.
REQ-038 Start a 32-bit sequence and assert clr at bit 10 -> dout=0 from the next cycle and stays 0; then a new start of bdout=1, msbidx=1, din=0x3 -> 3, confirming restart after clr.
